gigatron_video_out: RTL and testbench

Parametrised output stage between the Gigatron core's `OUT`/`XOUT` registers and a physical display/audio port. It registers and conditions the raw sync/colour byte:
- colour expanded to `COLOR_BITS` per channel by bit replication,
- sync polarity selectable,
- pixel/line counters regenerated from the software-driven sync edges to produce data-enable, pixel coordinates, frame-start and lock status.

It also latches `XOUT` on the hsync rising edge, as the original board does.

---
 rtl/gigatron_video_pkg.sv | 27 ++
 rtl/gigatron_video_out_if.sv | 44 ++++
 rtl/gigatron_sync_counter.sv | 55 +++++
 rtl/gigatron_video_out.sv | 180 ++++++++++++++++++
 tb/tb_gigatron_video_out.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/gigatron_video_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gigatron_video_pkg
// Purpose : Default Gigatron video timing and the colour bit-replication helper.
// Revision: 1.0  initial release
// ============================================================================
package gigatron_video_pkg;

    localparam int H_BACK   = 12;
    localparam int H_ACTIVE = 160;
    localparam int V_BACK   = 33;
    localparam int V_ACTIVE = 480;

    // Repeat the 2-bit level MSB-first across n output bits (n <= 32).
    function automatic logic [31:0] expand_color(input logic [1:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r = r | ({31'd0, ((i % 2) == 0) ? v[1] : v[0]} << (n - 1 - i));
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gigatron_video_out_if.sv
`default_nettype none
// ============================================================================
// Module  : gigatron_video_out_if
// Purpose : OUT/XOUT sample bus and conditioned video/audio port bundle.
// Revision: 1.0  initial release
// ============================================================================
interface gigatron_video_out_if #(
    parameter int COLOR_BITS = 8,
    parameter int H_ACTIVE   = gigatron_video_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = gigatron_video_pkg::V_ACTIVE
);
    localparam int X_W = $clog2(H_ACTIVE);
    localparam int Y_W = $clog2(V_ACTIVE);

    logic                  i_ce;
    logic [7:0]            i_out;
    logic [7:0]            i_xout;
    logic                  o_hsync;
    logic                  o_vsync;
    logic [COLOR_BITS-1:0] o_red;
    logic [COLOR_BITS-1:0] o_green;
    logic [COLOR_BITS-1:0] o_blue;
    logic                  o_de;
    logic [X_W-1:0]        o_x;
    logic [Y_W-1:0]        o_y;
    logic                  o_frame_start;
    logic                  o_locked;
    logic [3:0]            o_led;
    logic [3:0]            o_dac;

    modport master (
        output i_ce, i_out, i_xout,
        input  o_hsync, o_vsync, o_red, o_green, o_blue, o_de, o_x, o_y,
               o_frame_start, o_locked, o_led, o_dac
    );

    modport slave (
        input  i_ce, i_out, i_xout,
        output o_hsync, o_vsync, o_red, o_green, o_blue, o_de, o_x, o_y,
               o_frame_start, o_locked, o_led, o_dac
    );

endinterface
`default_nettype wire

// File: rtl/gigatron_sync_counter.sv
`default_nettype none
// ============================================================================
// Module  : gigatron_sync_counter
// Purpose : Clear/increment/saturate counter with active-window compare/offset.
// Revision: 1.0  initial release
// ============================================================================
module gigatron_sync_counter #(
    parameter int WIDTH   = 9,
    parameter int START   = 12,
    parameter int LENGTH  = 160,
    parameter int INDEX_W = $clog2(LENGTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               clear,
    input  logic               inc,
    output logic               active,
    output logic [INDEX_W-1:0] index,
    output logic               saturated,
    output logic               past_end
);
    localparam logic [WIDTH-1:0] C_START = WIDTH'(START);
    localparam logic [WIDTH-1:0] C_END   = WIDTH'(START + LENGTH);
    localparam logic [WIDTH-1:0] C_MAX   = '1;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (clear) begin
            w_next = '0;
        end else if (inc && (r_count != C_MAX)) begin
            w_next = r_count + 1'b1;
        end
    end

    // Resetting to all-ones keeps the window closed until a real sync edge arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= C_MAX;
        end else if (ce) begin
            r_count <= w_next;
        end
    end

    // Window flags describe the position of the sample being taken this cycle.
    assign active    = (w_next >= C_START) && (w_next < C_END);
    assign index     = active ? INDEX_W'(w_next - C_START) : '0;
    assign saturated = (w_next == C_MAX);
    assign past_end  = (r_count >= C_END) && (r_count != C_MAX);

endmodule
`default_nettype wire

// File: rtl/gigatron_video_out.sv
`default_nettype none
// ============================================================================
// Module  : gigatron_video_out
// Purpose : Registered Gigatron OUT/XOUT conditioning with regenerated timing.
// Revision: 1.0  initial release
// ============================================================================
module gigatron_video_out #(
    parameter int COLOR_BITS          = 8,
    parameter int H_BACK              = gigatron_video_pkg::H_BACK,
    parameter int H_ACTIVE            = gigatron_video_pkg::H_ACTIVE,
    parameter int V_BACK              = gigatron_video_pkg::V_BACK,
    parameter int V_ACTIVE            = gigatron_video_pkg::V_ACTIVE,
    parameter int OUT_SYNC_ACTIVE_LOW = 1,
    parameter int BLANK               = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    gigatron_video_out_if.slave  vid
);
    import gigatron_video_pkg::*;

    localparam int   HC_W        = $clog2(H_BACK + H_ACTIVE + 1) + 1;
    localparam int   VC_W        = $clog2(V_BACK + V_ACTIVE + 1) + 1;
    localparam int   X_W         = $clog2(H_ACTIVE);
    localparam int   Y_W         = $clog2(V_ACTIVE);
    localparam logic C_SYNC_IDLE = (OUT_SYNC_ACTIVE_LOW != 0);

    logic r_rst_meta;
    logic r_rst_n;

    // Reset asserts asynchronously everywhere but releases two clocks later.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    logic                  r_prev_hs_n;
    logic                  r_prev_vs_n;
    logic                  r_hsync;
    logic                  r_vsync;
    logic [COLOR_BITS-1:0] r_red;
    logic [COLOR_BITS-1:0] r_green;
    logic [COLOR_BITS-1:0] r_blue;
    logic                  r_de;
    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;
    logic                  r_frame_start;
    logic                  r_locked;
    logic [3:0]            r_led;
    logic [3:0]            r_dac;

    logic                  w_hs_n;
    logic                  w_vs_n;
    logic                  w_h_rise;
    logic                  w_v_rise;
    logic                  w_h_active;
    logic                  w_v_active;
    logic [X_W-1:0]        w_h_index;
    logic [Y_W-1:0]        w_v_index;
    logic                  w_h_sat;
    logic                  w_v_past_end;
    logic                  w_unused_h_past_end;
    logic                  w_unused_v_sat;
    logic                  w_de;
    logic                  w_show;
    logic [COLOR_BITS-1:0] w_red;
    logic [COLOR_BITS-1:0] w_green;
    logic [COLOR_BITS-1:0] w_blue;

    assign w_hs_n   = vid.i_out[6];
    assign w_vs_n   = vid.i_out[7];
    assign w_h_rise = vid.i_ce && !r_prev_hs_n && w_hs_n;
    assign w_v_rise = vid.i_ce && !r_prev_vs_n && w_vs_n;

    gigatron_sync_counter #(
        .WIDTH   (HC_W),
        .START   (H_BACK),
        .LENGTH  (H_ACTIVE),
        .INDEX_W (X_W)
    ) u_hcount (
        .clk       (i_clock),
        .rst_n     (r_rst_n),
        .ce        (vid.i_ce),
        .clear     (w_h_rise),
        .inc       (1'b1),
        .active    (w_h_active),
        .index     (w_h_index),
        .saturated (w_h_sat),
        .past_end  (w_unused_h_past_end)
    );

    // Vertical clear has priority over the hsync increment inside the counter.
    gigatron_sync_counter #(
        .WIDTH   (VC_W),
        .START   (V_BACK),
        .LENGTH  (V_ACTIVE),
        .INDEX_W (Y_W)
    ) u_vcount (
        .clk       (i_clock),
        .rst_n     (r_rst_n),
        .ce        (vid.i_ce),
        .clear     (w_v_rise),
        .inc       (w_h_rise),
        .active    (w_v_active),
        .index     (w_v_index),
        .saturated (w_unused_v_sat),
        .past_end  (w_v_past_end)
    );

    assign w_de    = w_h_active && w_v_active;
    assign w_show  = (BLANK == 0) || w_de;
    assign w_red   = COLOR_BITS'(expand_color(vid.i_out[1:0], COLOR_BITS));
    assign w_green = COLOR_BITS'(expand_color(vid.i_out[3:2], COLOR_BITS));
    assign w_blue  = COLOR_BITS'(expand_color(vid.i_out[5:4], COLOR_BITS));

    always_ff @(posedge i_clock or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_prev_hs_n   <= 1'b1;
            r_prev_vs_n   <= 1'b1;
            r_hsync       <= C_SYNC_IDLE;
            r_vsync       <= C_SYNC_IDLE;
            r_red         <= '0;
            r_green       <= '0;
            r_blue        <= '0;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_led         <= '0;
            r_dac         <= '0;
        end else begin
            r_frame_start <= 1'b0;
            if (vid.i_ce) begin
                r_prev_hs_n   <= w_hs_n;
                r_prev_vs_n   <= w_vs_n;
                r_hsync       <= (OUT_SYNC_ACTIVE_LOW != 0) ? w_hs_n : !w_hs_n;
                r_vsync       <= (OUT_SYNC_ACTIVE_LOW != 0) ? w_vs_n : !w_vs_n;
                r_red         <= w_show ? w_red   : '0;
                r_green       <= w_show ? w_green : '0;
                r_blue        <= w_show ? w_blue  : '0;
                r_de          <= w_de;
                r_x           <= w_de ? w_h_index : '0;
                r_y           <= w_de ? w_v_index : '0;
                r_frame_start <= w_de && (w_h_index == '0) && (w_v_index == '0);
                if (w_h_rise) begin
                    r_led <= vid.i_xout[3:0];
                    r_dac <= vid.i_xout[7:4];
                end
                // A lost hsync overrides whatever the vsync edge just concluded.
                if (w_v_rise) begin
                    r_locked <= w_v_past_end;
                end
                if (w_h_sat) begin
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign vid.o_hsync       = r_hsync;
    assign vid.o_vsync       = r_vsync;
    assign vid.o_red         = r_red;
    assign vid.o_green       = r_green;
    assign vid.o_blue        = r_blue;
    assign vid.o_de          = r_de;
    assign vid.o_x           = r_x;
    assign vid.o_y           = r_y;
    assign vid.o_frame_start = r_frame_start;
    assign vid.o_locked      = r_locked;
    assign vid.o_led         = r_led;
    assign vid.o_dac         = r_dac;

endmodule
`default_nettype wire

// File: tb/tb_gigatron_video_out.sv
`default_nettype none
// ============================================================================
// Module  : tb_gigatron_video_out
// Purpose : Randomised frame stimulus on two DUT configurations against a model.
// Revision: 1.0  initial release
// ============================================================================
module tb_gigatron_video_out;

    localparam int HB    = 12;
    localparam int HA    = 160;
    localparam int VB    = 3;
    localparam int VA    = 20;
    localparam int LINES = 30;
    localparam int LINE  = 200;
    localparam int HMAX  = (1 << ($clog2(HB + HA + 1) + 1)) - 1;
    localparam int VMAX  = (1 << ($clog2(VB + VA + 1) + 1)) - 1;

    logic clk;
    logic rst_n;

    gigatron_video_out_if #(.COLOR_BITS(8), .H_ACTIVE(HA), .V_ACTIVE(VA)) bus_a ();
    gigatron_video_out_if #(.COLOR_BITS(5), .H_ACTIVE(HA), .V_ACTIVE(VA)) bus_b ();

    gigatron_video_out #(
        .COLOR_BITS(8), .H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA),
        .OUT_SYNC_ACTIVE_LOW(1), .BLANK(1)
    ) dut_a (
        .i_clock (clk),
        .i_reset (rst_n),
        .vid     (bus_a)
    );

    gigatron_video_out #(
        .COLOR_BITS(5), .H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA),
        .OUT_SYNC_ACTIVE_LOW(0), .BLANK(0)
    ) dut_b (
        .i_clock (clk),
        .i_reset (rst_n),
        .vid     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of what the outputs should show after the latest enabled sample.
    bit       m_prev_h, m_prev_v, m_locked, m_de, m_fs, m_hs_n, m_vs_n;
    int       m_hpos, m_vpos, m_x, m_y;
    bit [1:0] m_r, m_g, m_b;
    bit [3:0] m_led, m_dac;

    int       de_cnt, fs_cnt, max_x, max_y;
    bit [7:0] g_xout;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rep_col(input bit [1:0] v, input int n);
        logic [31:0] rep;
        rep = {16{v}};
        return rep >> (32 - n);
    endfunction

    task automatic model_reset();
        m_prev_h = 1; m_prev_v = 1; m_locked = 0; m_de = 0; m_fs = 0;
        m_hs_n = 1; m_vs_n = 1; m_hpos = HMAX; m_vpos = VMAX; m_x = 0; m_y = 0;
        m_r = 0; m_g = 0; m_b = 0; m_led = 0; m_dac = 0;
    endtask

    task automatic model_step(input bit ce, input bit [7:0] o, input bit [7:0] xo);
        bit hr, vr;
        m_fs = 0;
        if (!ce) return;
        hr = !m_prev_h && o[6];
        vr = !m_prev_v && o[7];
        if (vr) m_locked = (m_vpos >= VB + VA) && (m_vpos != VMAX);
        if (hr) m_hpos = 0; else if (m_hpos < HMAX) m_hpos++;
        if (vr) m_vpos = 0; else if (hr && m_vpos < VMAX) m_vpos++;
        if (m_hpos == HMAX) m_locked = 0;
        m_de = (m_hpos >= HB) && (m_hpos < HB + HA) && (m_vpos >= VB) && (m_vpos < VB + VA);
        m_x  = m_de ? m_hpos - HB : 0;
        m_y  = m_de ? m_vpos - VB : 0;
        m_fs = m_de && m_x == 0 && m_y == 0;
        if (hr) begin m_led = xo[3:0]; m_dac = xo[7:4]; end
        m_hs_n = o[6]; m_vs_n = o[7];
        m_r = o[1:0]; m_g = o[3:2]; m_b = o[5:4];
        m_prev_h = o[6]; m_prev_v = o[7];
    endtask

    task automatic compare_all();
        logic [7:0] ra, ga, ba;
        logic [4:0] rb, gb, bb;
        ra = m_de ? 8'(rep_col(m_r, 8)) : 8'd0;
        ga = m_de ? 8'(rep_col(m_g, 8)) : 8'd0;
        ba = m_de ? 8'(rep_col(m_b, 8)) : 8'd0;
        rb = 5'(rep_col(m_r, 5));
        gb = 5'(rep_col(m_g, 5));
        bb = 5'(rep_col(m_b, 5));
        check("outs_a",
              64'({bus_a.o_hsync, bus_a.o_vsync, bus_a.o_red, bus_a.o_green, bus_a.o_blue,
                   bus_a.o_de, bus_a.o_x, bus_a.o_y, bus_a.o_frame_start, bus_a.o_locked,
                   bus_a.o_led, bus_a.o_dac}),
              64'({m_hs_n, m_vs_n, ra, ga, ba, m_de, 8'(m_x), 5'(m_y), m_fs, m_locked,
                   m_led, m_dac}));
        check("outs_b",
              64'({bus_b.o_hsync, bus_b.o_vsync, bus_b.o_red, bus_b.o_green, bus_b.o_blue,
                   bus_b.o_de, bus_b.o_x, bus_b.o_y, bus_b.o_frame_start, bus_b.o_locked,
                   bus_b.o_led, bus_b.o_dac}),
              64'({!m_hs_n, !m_vs_n, rb, gb, bb, m_de, 8'(m_x), 5'(m_y), m_fs, m_locked,
                   m_led, m_dac}));
    endtask

    task automatic drive(input bit ce, input bit [7:0] o, input bit [7:0] xo);
        bus_a.i_ce = ce; bus_a.i_out = o; bus_a.i_xout = xo;
        bus_b.i_ce = ce; bus_b.i_out = o; bus_b.i_xout = xo;
        @(posedge clk);
        #1;
        if (rst_n) model_step(ce, o, xo); else model_reset();
        compare_all();
        if (bus_a.o_de) begin
            de_cnt++;
            if (int'(bus_a.o_x) > max_x) max_x = int'(bus_a.o_x);
            if (int'(bus_a.o_y) > max_y) max_y = int'(bus_a.o_y);
        end
        if (bus_a.o_frame_start) fs_cnt++;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        repeat (4) drive(1'b0, 8'($urandom), 8'($urandom));
    endtask

    task automatic do_async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_async_de", 64'(bus_a.o_de), 64'd0);
        repeat (3) drive(1'($urandom), 8'($urandom), 8'($urandom));
        release_reset();
    endtask

    task automatic run_frame(input bit half, input bit rand_col, input bit fixed_chk,
                             input bit xtest, input int rst_line);
        bit [5:0] rgb;
        de_cnt = 0; fs_cnt = 0; max_x = 0; max_y = 0;
        for (int l = 0; l < LINES; l++) begin
            for (int p = 0; p < LINE; p++) begin
                if (l == rst_line && p == 80) begin
                    do_async_reset();
                    return;
                end
                rgb = rand_col ? 6'($urandom) : 6'b10_01_11;
                if (xtest && l == 10 && p == 100) g_xout = 8'h5A;
                drive(1'b1, {(l >= 2), (p >= 24), rgb}, g_xout);
                if (half) drive(1'b0, 8'($urandom), 8'($urandom));
                if (fixed_chk && l == 10 && p == 50) begin
                    check("px_red_a",   64'(bus_a.o_red),   64'hFF);
                    check("px_green_a", 64'(bus_a.o_green), 64'h55);
                    check("px_blue_a",  64'(bus_a.o_blue),  64'hAA);
                    check("px_rgb_b",   64'({bus_b.o_red, bus_b.o_green, bus_b.o_blue}),
                          64'({5'h1F, 5'h0A, 5'h15}));
                    check("px_xy", 64'({bus_a.o_x, bus_a.o_y}), 64'({8'd14, 5'd6}));
                end
                if (xtest && l == 10 && p == 150)
                    check("xout_hold", 64'({bus_a.o_dac, bus_a.o_led}), 64'h00);
                if (xtest && l == 11 && p == 23)
                    check("xout_pre_edge", 64'({bus_a.o_dac, bus_a.o_led}), 64'h00);
                if (xtest && l == 11 && p == 24)
                    check("xout_load", 64'({bus_a.o_dac, bus_a.o_led}), 64'h5A);
            end
        end
    endtask

    int loss_de;

    initial begin
        rst_n  = 1'b0;
        g_xout = 8'h00;
        model_reset();
        repeat (3) drive(1'($urandom), 8'($urandom), 8'($urandom));
        release_reset();
        check("rst_locked", 64'(bus_a.o_locked), 64'd0);
        check("rst_de",     64'(bus_a.o_de), 64'd0);
        check("rst_sync_a", 64'({bus_a.o_hsync, bus_a.o_vsync}), 64'd3);
        check("rst_sync_b", 64'({bus_b.o_hsync, bus_b.o_vsync}), 64'd0);

        run_frame(0, 0, 1, 0, -1);
        check("f1_de_count", 64'(de_cnt), 64'(HA * VA));
        check("f1_fs_count", 64'(fs_cnt), 64'd1);
        check("f1_max_xy",   64'({max_x[15:0], max_y[15:0]}), 64'({16'(HA - 1), 16'(VA - 1)}));
        check("f1_unlocked", 64'(bus_a.o_locked), 64'd0);

        run_frame(0, 0, 1, 0, -1);
        check("f2_de_count", 64'(de_cnt), 64'(HA * VA));
        check("f2_fs_count", 64'(fs_cnt), 64'd1);
        check("f2_locked",   64'(bus_a.o_locked), 64'd1);

        run_frame(0, 1, 0, 1, -1);
        check("f3_de_count", 64'(de_cnt), 64'(HA * VA));
        check("f3_locked",   64'(bus_a.o_locked), 64'd1);

        de_cnt = 0;
        for (int i = 0; i < 2000; i++) drive(1'b1, {1'b1, 1'b0, 6'($urandom)}, g_xout);
        loss_de = de_cnt;
        check("hloss_de",     64'(loss_de), 64'd0);
        check("hloss_locked", 64'(bus_a.o_locked), 64'd0);

        run_frame(1, 1, 0, 0, -1);
        check("half_fs_count", 64'(fs_cnt), 64'd1);
        run_frame(1, 1, 0, 0, 8);

        run_frame(0, 1, 0, 0, -1);
        check("post_rst_de",     64'(de_cnt), 64'(HA * VA));
        check("post_rst_locked", 64'(bus_a.o_locked), 64'd0);
        run_frame(0, 1, 0, 0, -1);
        check("relock", 64'(bus_a.o_locked), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
